// File: rtl/decode_control_unit.sv
// decode_control_unit: registered multi-thread MIPS control decoder with
// per-thread sticky halt flags and LL/SC link tracking.
module decode_control_unit #(
    parameter int NTHREADS = 2,
    localparam int TID_W = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                dec_valid,
    input  logic [TID_W-1:0]    dec_tid,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                stall,
    input  logic                flush,
    input  logic [NTHREADS-1:0] linkclr,
    output logic                ready,
    output logic                ctl_valid,
    output logic [TID_W-1:0]    ctl_tid,
    output logic [2:0]          PCSrc,
    output logic [3:0]          ALUOp,
    output logic                WrLinkReg,
    output logic                ShiftUp,
    output logic                MemRd,
    output logic                ExtOp,
    output logic                ALUSrc,
    output logic                MemToReg,
    output logic                MemWr,
    output logic                RegWr,
    output logic                RegDst,
    output logic                Atomic,
    output logic                halt,
    output logic                ScForceFail,
    output logic [NTHREADS-1:0] halted,
    output logic                all_halted
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                           OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                           OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_LL = 6'h30,
                           OP_SC = 6'h38, OP_HALT = 6'h3E;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                           F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                           F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
                           F_SLTU = 6'h2B;
    localparam logic [3:0] ALU_SLL = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                           ALU_OR = 4'd4, ALU_XOR = 4'd5, ALU_NOR = 4'd6, ALU_SLT = 4'd7,
                           ALU_SLTU = 4'd8, ALU_SRL = 4'd9;
    localparam logic [2:0] PC_NEXT = 3'd0, PC_JR = 3'd1, PC_BEQ = 3'd2, PC_BNE = 3'd3,
                           PC_JUMP = 3'd4;

    typedef struct packed {
        logic [2:0] pcsrc;
        logic [3:0] aluop;
        logic       wrlink;
        logic       shiftup;
        logic       memrd;
        logic       extop;
        logic       alusrc;
        logic       memtoreg;
        logic       memwr;
        logic       regwr;
        logic       regdst;
        logic       atomic;
        logic       halt;
        logic       scff;
    } ctl_t;

    ctl_t                dec, ctl_d, ctl_q;
    logic                valid_d, valid_q;
    logic [TID_W-1:0]    tid, tid_d, tid_q;
    logic [NTHREADS-1:0] link_d, link_q, halted_d, halted_q;
    logic                accept;

    assign tid    = (NTHREADS == 1) ? '0 : dec_tid;
    assign accept = dec_valid && !stall && !flush && !halted_q[tid];

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.regwr  = 1'b1;
                dec.regdst = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: dec.aluop = ALU_ADD;
                    F_SUB, F_SUBU: dec.aluop = ALU_SUB;
                    F_AND:         dec.aluop = ALU_AND;
                    F_OR:          dec.aluop = ALU_OR;
                    F_XOR:         dec.aluop = ALU_XOR;
                    F_NOR:         dec.aluop = ALU_NOR;
                    F_SLT:         dec.aluop = ALU_SLT;
                    F_SLTU:        dec.aluop = ALU_SLTU;
                    F_SLL:         dec.aluop = ALU_SLL;
                    F_SRL:         dec.aluop = ALU_SRL;
                    F_JR:          {dec.pcsrc, dec.regwr, dec.regdst} = {PC_JR, 2'b00};
                    default:       {dec.regwr, dec.regdst} = 2'b00;
                endcase
            end
            OP_ADDI, OP_ADDIU: {dec.aluop, dec.alusrc, dec.extop, dec.regwr} = {ALU_ADD, 3'b111};
            OP_SLTI:  {dec.aluop, dec.alusrc, dec.extop, dec.regwr} = {ALU_SLT, 3'b111};
            OP_SLTIU: {dec.aluop, dec.alusrc, dec.extop, dec.regwr} = {ALU_SLTU, 3'b111};
            OP_ANDI:  {dec.aluop, dec.alusrc, dec.regwr} = {ALU_AND, 2'b11};
            OP_ORI:   {dec.aluop, dec.alusrc, dec.regwr} = {ALU_OR, 2'b11};
            OP_XORI:  {dec.aluop, dec.alusrc, dec.regwr} = {ALU_XOR, 2'b11};
            OP_LUI:   {dec.shiftup, dec.regwr} = 2'b11;
            OP_LW, OP_LL: begin
                {dec.aluop, dec.memrd, dec.memtoreg, dec.alusrc, dec.extop, dec.regwr} = {ALU_ADD, 5'b11111};
                dec.atomic = (opcode == OP_LL);
            end
            OP_SW, OP_SC: begin
                {dec.aluop, dec.memwr, dec.alusrc, dec.extop} = {ALU_ADD, 3'b111};
                {dec.atomic, dec.regwr, dec.memtoreg} = {3{opcode == OP_SC}};
            end
            OP_BEQ:   {dec.aluop, dec.pcsrc, dec.extop} = {ALU_SUB, PC_BEQ, 1'b1};
            OP_BNE:   {dec.aluop, dec.pcsrc, dec.extop} = {ALU_SUB, PC_BNE, 1'b1};
            OP_J:     dec.pcsrc = PC_JUMP;
            OP_JAL:   {dec.pcsrc, dec.wrlink, dec.regwr} = {PC_JUMP, 2'b11};
            OP_HALT:  dec.halt = 1'b1;
            default:  dec = '0;
        endcase
    end

    // Output register loads every non-stalled edge (flush overrides stall); idle loads are cleared bundles.
    always_comb begin
        ctl_d    = (flush || !stall) ? '0 : ctl_q;
        valid_d  = (flush || !stall) ? 1'b0 : valid_q;
        tid_d    = (flush || !stall) ? '0 : tid_q;
        link_d   = link_q & ~linkclr;
        halted_d = halted_q;
        if (accept) begin
            ctl_d      = dec;
            ctl_d.scff = (opcode == OP_SC) && !link_q[tid];
            valid_d    = 1'b1;
            tid_d      = tid;
            if (opcode == OP_SC) link_d[tid] = 1'b0;
            if (opcode == OP_LL) link_d[tid] = 1'b1;
            if (opcode == OP_HALT) halted_d[tid] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctl_q    <= '0;
            valid_q  <= 1'b0;
            tid_q    <= '0;
            link_q   <= '0;
            halted_q <= '0;
        end else begin
            ctl_q    <= ctl_d;
            valid_q  <= valid_d;
            tid_q    <= tid_d;
            link_q   <= link_d;
            halted_q <= halted_d;
        end
    end

    assign ready      = !stall;
    assign ctl_valid  = valid_q;
    assign ctl_tid    = tid_q;
    assign halted     = halted_q;
    assign all_halted = &halted_q;
    assign {PCSrc, ALUOp, WrLinkReg, ShiftUp, MemRd, ExtOp, ALUSrc, MemToReg, MemWr,
            RegWr, RegDst, Atomic, halt, ScForceFail} = ctl_q;
endmodule

// File: tb/tb_decode_control_unit.sv
// tb_decode_control_unit: scoreboard bench; a signal-equation reference model
// predicts each bundle, a monitor compares what the DUT presents.
module tb_decode_control_unit;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                           OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                           OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_LL = 6'h30,
                           OP_SC = 6'h38, OP_HALT = 6'h3E, OP_BAD = 6'h3F;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                           F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                           F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
                           F_SLTU = 6'h2B;

    typedef struct packed {
        logic       valid;
        logic       tid;
        logic [2:0] pcsrc;
        logic [3:0] aluop;
        logic       wrlink, shiftup, memrd, extop, alusrc, memtoreg;
        logic       memwr, regwr, regdst, atomic, halt, scff;
        logic [1:0] halted;
        logic       all_halted;
    } exp_t;

    logic       CLK = 0, RST = 1, dec_valid = 0, dec_tid = 0, stall = 0, flush = 0;
    logic [5:0] opcode = 0, funct = 0;
    logic [1:0] linkclr = 0;
    logic       ready, ctl_valid, ctl_tid, WrLinkReg, ShiftUp, MemRd, ExtOp, ALUSrc;
    logic       MemToReg, MemWr, RegWr, RegDst, Atomic, halt, ScForceFail, all_halted;
    logic [2:0] PCSrc;
    logic [3:0] ALUOp;
    logic [1:0] halted;

    decode_control_unit #(.NTHREADS(2)) dut (
        .CLK(CLK), .RST(RST), .dec_valid(dec_valid), .dec_tid(dec_tid), .opcode(opcode),
        .funct(funct), .stall(stall), .flush(flush), .linkclr(linkclr), .ready(ready),
        .ctl_valid(ctl_valid), .ctl_tid(ctl_tid), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .WrLinkReg(WrLinkReg), .ShiftUp(ShiftUp), .MemRd(MemRd), .ExtOp(ExtOp),
        .ALUSrc(ALUSrc), .MemToReg(MemToReg), .MemWr(MemWr), .RegWr(RegWr),
        .RegDst(RegDst), .Atomic(Atomic), .halt(halt), .ScForceFail(ScForceFail),
        .halted(halted), .all_halted(all_halted)
    );

    always #5 CLK = ~CLK;

    int         total = 0, bad = 0;
    exp_t       q[$];
    logic [1:0] m_link, m_halted;
    logic [3:0] alu_of_op[64], alu_of_fn[64];
    bit         last_load = 0, started = 0, done = 0;

    // ALU operation per opcode/funct as a lookup table; unlisted entries stay SLL (0).
    task automatic init_tables();
        for (int i = 0; i < 64; i++) begin
            alu_of_op[i] = 4'd0;
            alu_of_fn[i] = 4'd0;
        end
        alu_of_op[OP_ADDI] = 1; alu_of_op[OP_ADDIU] = 1; alu_of_op[OP_LW] = 1;
        alu_of_op[OP_SW] = 1; alu_of_op[OP_LL] = 1; alu_of_op[OP_SC] = 1;
        alu_of_op[OP_SLTI] = 7; alu_of_op[OP_SLTIU] = 8; alu_of_op[OP_ANDI] = 3;
        alu_of_op[OP_ORI] = 4; alu_of_op[OP_XORI] = 5; alu_of_op[OP_BEQ] = 2; alu_of_op[OP_BNE] = 2;
        alu_of_fn[F_ADD] = 1; alu_of_fn[F_ADDU] = 1; alu_of_fn[F_SUB] = 2; alu_of_fn[F_SUBU] = 2;
        alu_of_fn[F_AND] = 3; alu_of_fn[F_OR] = 4; alu_of_fn[F_XOR] = 5; alu_of_fn[F_NOR] = 6;
        alu_of_fn[F_SLT] = 7; alu_of_fn[F_SLTU] = 8; alu_of_fn[F_SLL] = 0; alu_of_fn[F_SRL] = 9;
    endtask

    function automatic exp_t ref_decode(logic [5:0] op, logic [5:0] fn);
        exp_t e = '0;
        bit r  = (op == OP_RTYPE);
        bit rk = r && (fn inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                                  F_SLT, F_SLTU, F_SLL, F_SRL});
        bit jr = r && (fn == F_JR);
        e.regwr    = rk || (op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
                                       OP_XORI, OP_LUI, OP_LW, OP_LL, OP_SC, OP_JAL});
        e.regdst   = rk;
        e.alusrc   = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
                                OP_LW, OP_SW, OP_LL, OP_SC};
        e.extop    = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW, OP_LL,
                                OP_SC, OP_BEQ, OP_BNE};
        e.shiftup  = (op == OP_LUI);
        e.memrd    = op inside {OP_LW, OP_LL};
        e.memwr    = op inside {OP_SW, OP_SC};
        e.memtoreg = op inside {OP_LW, OP_LL, OP_SC};
        e.atomic   = op inside {OP_LL, OP_SC};
        e.wrlink   = (op == OP_JAL);
        e.halt     = (op == OP_HALT);
        e.pcsrc    = jr ? 3'd1 : (op == OP_BEQ) ? 3'd2 : (op == OP_BNE) ? 3'd3 :
                     (op inside {OP_J, OP_JAL}) ? 3'd4 : 3'd0;
        e.aluop    = rk ? alu_of_fn[fn] : r ? 4'd0 : alu_of_op[op];
        return e;
    endfunction

    task automatic push(exp_t e);
        e.halted     = m_halted;
        e.all_halted = &m_halted;
        q.push_back(e);
    endtask

    // Drive one cycle, advance the model to the state after the coming edge, then take the edge.
    task automatic step(bit r, bit v, int t, logic [5:0] op, logic [5:0] fn,
                        bit st = 0, bit fl = 0, logic [1:0] lc = 2'b00);
        exp_t e = '0;
        bit   acc, old;
        RST = r; dec_valid = v; dec_tid = t[0]; opcode = op; funct = fn;
        stall = st; flush = fl; linkclr = lc;
        if (r) begin
            m_link = 0;
            m_halted = 0;
            push(e);
        end else begin
            acc = v && !st && !fl && !m_halted[t];
            old = m_link[t];
            m_link &= ~lc;
            if (acc) begin
                e = ref_decode(op, fn);
                e.valid = 1;
                e.tid = t[0];
                if (op == OP_SC) begin
                    e.scff = !old;
                    m_link[t] = 0;
                end
                if (op == OP_LL) m_link[t] = 1;
                if (op == OP_HALT) m_halted[t] = 1;
            end
            if (fl || !st) push(e);
        end
        @(posedge CLK);
        #1;
        last_load = r || fl || !st;
    endtask

    task automatic idle(int n = 1);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Monitor: each loading edge presents the next queued bundle; stalled edges must hold it.
    initial begin
        exp_t act, held;
        held = '0;
        wait (started);
        forever begin
            @(negedge CLK);
            if (done) break;
            act = {ctl_valid, ctl_tid, PCSrc, ALUOp, WrLinkReg, ShiftUp, MemRd, ExtOp, ALUSrc,
                   MemToReg, MemWr, RegWr, RegDst, Atomic, halt, ScForceFail, halted, all_halted};
            total++;
            if (ready !== !stall) begin
                bad++;
                $display("FAIL ready t=%0t got=%b want=%b", $time, ready, !stall);
            end
            if (last_load) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL bundle t=%0t got=%h want=<none queued>", $time, act);
                end else begin
                    held = q.pop_front();
                    if (act !== held) begin
                        bad++;
                        $display("FAIL bundle t=%0t got=%h want=%h", $time, act, held);
                    end
                end
            end else begin
                total++;
                if (act !== held) begin
                    bad++;
                    $display("FAIL bundle_hold t=%0t got=%h want=%h", $time, act, held);
                end
            end
        end
    end

    initial begin
        logic [5:0] ops[19] = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                                OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW,
                                OP_SW, OP_LL, OP_SC, OP_BAD, OP_RTYPE};
        logic [5:0] fns[15] = '{F_SLL, F_SRL, F_JR, F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
                                F_XOR, F_NOR, F_SLT, F_SLTU, 6'h3F, 6'h01};
        logic [5:0] op;
        init_tables();
        m_link = 0;
        m_halted = 0;
        step(1, 0, 0, 0, 0);
        started = 1;
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, OP_ADDI, 0);
        step(0, 1, 1, OP_RTYPE, F_SUB);
        step(1, 1, 0, OP_LW, 0);
        idle();
        // LL/SC on one thread, then a second SC without a link
        step(0, 1, 0, OP_LL, 0);
        step(0, 1, 0, OP_SC, 0);
        step(0, 1, 0, OP_SC, 0);
        // thread 1 link killed by snoop; thread 0 link untouched
        step(0, 1, 0, OP_LL, 0);
        step(0, 1, 1, OP_LL, 0);
        step(0, 0, 0, 0, 0, 0, 0, 2'b10);
        step(0, 1, 1, OP_SC, 0);
        step(0, 1, 0, OP_SC, 0);
        // LL and snoop on the same thread in the same cycle: the link survives
        step(0, 1, 0, OP_LL, 0, 0, 0, 2'b01);
        step(0, 1, 0, OP_SC, 0);
        // stall held with LW presented, release, then flush during stall
        step(0, 1, 1, OP_ADDIU, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, OP_LW, 0, 1);
        step(0, 1, 0, OP_LW, 0);
        step(0, 1, 1, OP_SW, 0, 1);
        step(0, 1, 1, OP_SW, 0, 1, 1);
        step(0, 1, 1, OP_SW, 0, 0, 1);
        idle();
        // halts
        step(0, 1, 0, OP_HALT, 0);
        step(0, 1, 0, OP_RTYPE, F_ADD);
        step(0, 1, 1, OP_RTYPE, F_ADD);
        step(0, 1, 0, OP_LL, 0);
        step(0, 1, 1, OP_HALT, 0);
        step(0, 1, 1, OP_RTYPE, F_ADD);
        idle(2);
        step(1, 0, 0, 0, 0);
        // unknown opcode/funct and control-flow forms
        step(0, 1, 0, OP_BAD, 0);
        step(0, 1, 1, OP_RTYPE, 6'h3F);
        step(0, 1, 0, OP_RTYPE, F_JR);
        step(0, 1, 1, OP_J, 0);
        step(0, 1, 0, OP_JAL, 0);
        step(0, 1, 1, OP_BEQ, 0);
        step(0, 1, 0, OP_BNE, 0);
        step(0, 1, 1, OP_LUI, 0);
        step(0, 1, 0, OP_RTYPE, F_SRL, 1);
        step(1, 1, 0, OP_ANDI, 0, 1, 1);
        for (int i = 0; i < 600; i++) begin
            op = ops[$urandom_range(0, 18)];
            if ($urandom_range(0, 40) == 0) op = OP_HALT;
            step($urandom_range(0, 60) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 1),
                 op, fns[$urandom_range(0, 14)], $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end
        idle();
        @(negedge CLK);
        #1;
        done = 1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
